// File: rtl/spi_slave_rx_tx.sv
// Purpose : SPI mode-0 slave; deserialises Mosi into words and serialises host words onto Miso.
// Latency : 3 Clk edges from any pin edge to its registered effect; RxValid 3 Clk after the last Sclk rise.
// Backpr. : single holding register; TxWr ignored while TxFull=1, empty slot at load sends zeros + TxUnderrun.
//
// Ports:
//   Clk, Rst_n        system clock (rising edge), asynchronous active-low reset
//   Sclk, Cs_n, Mosi  SPI pins from the master, asynchronous to Clk
//   Miso              registered slave-out bit, 0 while Cs_n is high
//   TxData, TxWr      host word and one-cycle write strobe into the holding register
//   TxFull            holding register occupied
//   RxData, RxValid   last received word (MSB first on wire) and its one-cycle update pulse
//   TxUnderrun        one-cycle pulse: shifter loaded while the holding register was empty
//   FrameErr          one-cycle pulse: Cs_n rose part-way through a word
module spi_slave_rx_tx #(
    parameter int SIZE = 8
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Sclk,
    input  logic            Cs_n,
    input  logic            Mosi,
    output logic            Miso,
    input  logic [SIZE-1:0] TxData,
    input  logic            TxWr,
    output logic            TxFull,
    output logic [SIZE-1:0] RxData,
    output logic            RxValid,
    output logic            TxUnderrun,
    output logic            FrameErr
);

    localparam int CNT_W = $clog2(SIZE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    // IDLE: Cs_n high or no frame started yet.
    // SHIFT: inside a word, Sclk falls shift the tx word.
    // RELOAD: the last rise completed a word, so the next fall reloads instead of shifting.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    state_t state, state_next;

    // Synchronisers plus one extra stage on Sclk / Cs_n for edge detection
    logic sclk_s1, sclk_s2, sclk_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2;

    logic sclk_rise, sclk_fall, cs_fall;

    // Datapath state
    logic [CNT_W-1:0] bit_cnt;
    logic [SIZE-2:0]  rx_shift;   // bits received so far in the current word
    logic [SIZE-2:0]  tx_rest;    // tx bits not yet presented; Miso itself holds the current MSB
    logic [SIZE-1:0]  hold_dat;
    logic             hold_full;

    // Control decoded by the FSM
    logic do_load, do_shift, do_sample, word_done, frame_abort, frame_start;

    logic [SIZE-1:0] load_word;
    logic [SIZE-1:0] rx_word_next;
    logic [SIZE-1:0] tx_next;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= Sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= Cs_n;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= Mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign cs_fall   = ~cs_s2 & cs_s3;

    // An empty holding register sends an all-zero word
    assign load_word    = hold_full ? hold_dat : '0;
    assign rx_word_next = {rx_shift, mosi_s2};
    assign tx_next      = {tx_rest, 1'b0};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        do_load     = 1'b0;
        do_shift    = 1'b0;
        do_sample   = 1'b0;
        word_done   = 1'b0;
        frame_abort = 1'b0;
        frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                // A coincident Sclk rise is deliberately dropped: frame start wins.
                if (cs_fall) begin
                    frame_start = 1'b1;
                    do_load     = 1'b1;
                    state_next  = ST_SHIFT;
                end
            end
            ST_SHIFT, ST_RELOAD: begin
                if (cs_s2) begin
                    // Only reachable on the synced Cs_n rise; a non-zero count means a partial word.
                    state_next  = ST_IDLE;
                    frame_abort = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    do_sample = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        word_done  = 1'b1;
                        state_next = ST_RELOAD;
                    end
                end else if (sclk_fall) begin
                    if (state == ST_RELOAD) begin
                        do_load    = 1'b1;
                        state_next = ST_SHIFT;
                    end else begin
                        do_shift = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Miso       <= 1'b0;
            tx_rest    <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            RxData     <= '0;
            RxValid    <= 1'b0;
            TxUnderrun <= 1'b0;
            FrameErr   <= 1'b0;
            hold_dat   <= '0;
            hold_full  <= 1'b0;
        end else begin
            RxValid    <= 1'b0;
            TxUnderrun <= 1'b0;
            FrameErr   <= frame_abort;

            // Transmit side
            if (do_load) begin
                Miso       <= load_word[SIZE-1];
                tx_rest    <= load_word[SIZE-2:0];
                TxUnderrun <= ~hold_full;
            end else if (do_shift) begin
                Miso    <= tx_next[SIZE-1];
                tx_rest <= tx_next[SIZE-2:0];
            end else if (state_next == ST_IDLE) begin
                Miso <= 1'b0;
            end

            // Receive side and bit counter
            if (frame_start || frame_abort) begin
                bit_cnt <= '0;
            end else if (do_sample) begin
                rx_shift <= rx_word_next[SIZE-2:0];
                if (word_done) begin
                    RxData  <= rx_word_next;
                    RxValid <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            // Holding register: a load in the same cycle frees the slot for a new write
            if (do_load) begin
                hold_full <= 1'b0;
            end
            if (TxWr && (!hold_full || do_load)) begin
                hold_dat  <= TxData;
                hold_full <= 1'b1;
            end
        end
    end

    assign TxFull = hold_full;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
module tb_spi_slave_rx_tx;

    logic       Clk = 1'b0;
    logic       Rst_n, Sclk, Cs_n, Mosi, Miso, TxWr, TxFull, RxValid, TxUnderrun, FrameErr;
    logic [7:0] TxData, RxData;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Written only by the monitor
    int         rv_cnt  = 0;
    int         ur_cnt  = 0;
    int         fe_cnt  = 0;
    int         rv_cyc  = 0;
    logic [7:0] last_rx = '0;
    logic [7:0] prev_rx = '0;

    // Written only by the stimulus
    int rise_cyc = 0;

    typedef struct {
        logic       wr;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_ur;
    } vec_t;

    vec_t vecs[5];

    spi_slave_rx_tx #(.SIZE(8)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Sclk       (Sclk),
        .Cs_n       (Cs_n),
        .Mosi       (Mosi),
        .Miso       (Miso),
        .TxData     (TxData),
        .TxWr       (TxWr),
        .TxFull     (TxFull),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .TxUnderrun (TxUnderrun),
        .FrameErr   (FrameErr)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (RxValid) begin
            rv_cnt++;
            rv_cyc  = cyc;
            prev_rx = last_rx;
            last_rx = RxData;
        end
        if (TxUnderrun) ur_cnt++;
        if (FrameErr) fe_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge Clk);
        TxData = d;
        TxWr   = 1'b1;
        @(negedge Clk);
        TxWr   = 1'b0;
    endtask

    // Mode-0 master: Sclk high/low phases of 4 Clk each, Miso sampled just before each rise.
    // When 'last' is set, Cs_n rises together with the final Sclk fall.
    task automatic xfer_bits(input logic [7:0] m, input int nbits, input bit last,
                             output logic [7:0] s);
        s = '0;
        for (int i = 0; i < nbits; i++) begin
            Mosi = m[7-i];
            clk_wait(4);
            s[7-i]   = Miso;
            Sclk     = 1'b1;
            rise_cyc = cyc;
            clk_wait(4);
            Sclk = 1'b0;
            if (last && (i == nbits - 1)) Cs_n = 1'b1;
        end
    endtask

    task automatic frame1(input logic [7:0] m, output logic [7:0] s);
        Cs_n = 1'b0;
        xfer_bits(m, 8, 1'b1, s);
        clk_wait(8);
    endtask

    initial begin
        int         rv0, ur0, fe0;
        logic [7:0] s, s2;

        Rst_n  = 1'b0;
        Sclk   = 1'b0;
        Cs_n   = 1'b1;
        Mosi   = 1'b0;
        TxWr   = 1'b0;
        TxData = '0;

        vecs[0] = '{wr: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C, exp_ur: 0};
        vecs[1] = '{wr: 1'b0, tx: 8'h00, mosi: 8'h5A, exp_miso: 8'h00, exp_rx: 8'h5A, exp_ur: 1};
        vecs[2] = '{wr: 1'b1, tx: 8'hFF, mosi: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h00, exp_ur: 0};
        vecs[3] = '{wr: 1'b1, tx: 8'h01, mosi: 8'h80, exp_miso: 8'h01, exp_rx: 8'h80, exp_ur: 0};
        vecs[4] = '{wr: 1'b1, tx: 8'h6E, mosi: 8'hC7, exp_miso: 8'h6E, exp_rx: 8'hC7, exp_ur: 0};

        // Reset state
        clk_wait(3);
        check("rst_miso", Miso, 0);
        check("rst_rxdata", RxData, 0);
        check("rst_rxvalid", RxValid, 0);
        check("rst_txfull", TxFull, 0);
        check("rst_underrun", TxUnderrun, 0);
        check("rst_frameerr", FrameErr, 0);
        Rst_n = 1'b1;
        clk_wait(4);

        // Single-word frames from the table
        for (int v = 0; v < 5; v++) begin
            rv0 = rv_cnt;
            ur0 = ur_cnt;
            fe0 = fe_cnt;
            if (vecs[v].wr) begin
                tx_write(vecs[v].tx);
                check("txfull_after_wr", TxFull, 1);
            end
            frame1(vecs[v].mosi, s);
            check("miso_word", s, vecs[v].exp_miso);
            check("rxdata", RxData, vecs[v].exp_rx);
            check("rxvalid_pulses", rv_cnt - rv0, 1);
            check("rxvalid_latency", rv_cyc - rise_cyc, 3);
            check("underrun_pulses", ur_cnt - ur0, vecs[v].exp_ur);
            check("frameerr_pulses", fe_cnt - fe0, 0);
            check("txfull_after_frame", TxFull, 0);
        end

        // Two words in one frame, second word written during the first
        rv0 = rv_cnt;
        ur0 = ur_cnt;
        fe0 = fe_cnt;
        tx_write(8'h11);
        fork
            begin
                Cs_n = 1'b0;
                xfer_bits(8'hF0, 8, 1'b0, s);
                xfer_bits(8'h0F, 8, 1'b1, s2);
                clk_wait(8);
            end
            begin
                clk_wait(20);
                check("txfull_after_start", TxFull, 0);
                TxData = 8'h22;
                TxWr   = 1'b1;
                clk_wait(1);
                TxWr   = 1'b0;
                check("txfull_midframe_wr", TxFull, 1);
            end
        join
        check("two_miso_w1", s, 8'h11);
        check("two_miso_w2", s2, 8'h22);
        check("two_rx_w1", prev_rx, 8'hF0);
        check("two_rx_w2", last_rx, 8'h0F);
        check("two_rxvalid_pulses", rv_cnt - rv0, 2);
        check("two_underrun_pulses", ur_cnt - ur0, 0);
        check("two_frameerr_pulses", fe_cnt - fe0, 0);

        // Cs_n rises after 5 bits
        rv0 = rv_cnt;
        ur0 = ur_cnt;
        fe0 = fe_cnt;
        Cs_n = 1'b0;
        xfer_bits(8'hAA, 5, 1'b1, s);
        clk_wait(8);
        check("abort_frameerr_pulses", fe_cnt - fe0, 1);
        check("abort_rxvalid_pulses", rv_cnt - rv0, 0);
        check("abort_rxdata_kept", RxData, 8'h0F);
        check("abort_underrun_pulses", ur_cnt - ur0, 1);
        check("abort_miso_idle", Miso, 0);

        rv0 = rv_cnt;
        fe0 = fe_cnt;
        frame1(8'h96, s);
        check("recover_rxdata", RxData, 8'h96);
        check("recover_rxvalid_pulses", rv_cnt - rv0, 1);
        check("recover_frameerr_pulses", fe_cnt - fe0, 0);
        check("recover_miso_word", s, 8'h00);

        // Second write while full is dropped
        ur0 = ur_cnt;
        tx_write(8'h55);
        tx_write(8'h77);
        check("hold_txfull", TxFull, 1);
        frame1(8'h3A, s);
        check("hold_miso_word", s, 8'h55);
        check("hold_rxdata", RxData, 8'h3A);
        check("hold_txfull_after", TxFull, 0);
        check("hold_underrun_pulses", ur_cnt - ur0, 0);

        // Asynchronous reset part-way through a word
        tx_write(8'hFF);
        check("prerst_txfull", TxFull, 1);
        Cs_n = 1'b0;
        xfer_bits(8'hFF, 3, 1'b0, s);
        clk_wait(2);
        check("prerst_miso", Miso, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("midrst_miso", Miso, 0);
        check("midrst_rxdata", RxData, 0);
        check("midrst_txfull", TxFull, 0);
        check("midrst_rxvalid", RxValid, 0);
        check("midrst_underrun", TxUnderrun, 0);
        check("midrst_frameerr", FrameErr, 0);
        Cs_n = 1'b1;
        Sclk = 1'b0;
        clk_wait(3);
        Rst_n = 1'b1;
        clk_wait(4);

        rv0 = rv_cnt;
        ur0 = ur_cnt;
        frame1(8'h81, s);
        check("postrst_rxdata", RxData, 8'h81);
        check("postrst_rxvalid_pulses", rv_cnt - rv0, 1);
        check("postrst_miso_word", s, 8'h00);
        check("postrst_underrun_pulses", ur_cnt - ur0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
- SPI mode-0 slave (CPOL=0, CPHA=0): the responder end of the SPI link whose master bit rate comes from our prescaled pulse source.
- Oversamples the external Sclk, Cs_n and Mosi on the system clock.
- Deserialises Mosi into parallel words for the host and serialises one host-supplied word per frame slot onto Miso.
- Has a single transmit holding register and frame-error/underrun flags.

Parameters:
- SIZE, 8, word length in bits (≥2); also sets bit-counter width to clog2(SIZE).

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Sclk  in  1  SPI clock from master, asynchronous to Clk
- Cs_n  in  1  SPI chip select, active low, asynchronous
- Mosi  in  1  SPI master-out data, asynchronous
- Miso  out  1  SPI slave-out data, registered
- TxData  in  SIZE  word to transmit
- TxWr  in  1  one-cycle strobe, writes TxData into holding register
- TxFull  out  1  holding register occupied
- RxData  out  SIZE  last received word, MSB first on wire
- RxValid  out  1  one-cycle pulse, RxData updated
- TxUnderrun  out  1  one-cycle pulse, shifter loaded with no word available
- FrameErr  out  1  one-cycle pulse, Cs_n rose mid-word

Behaviour:
- Reset (async, Rst_n=0):
  - Miso=0, RxData=0, RxValid=0, TxFull=0, TxUnderrun=0, FrameErr=0.
  - Sync flops set to 0 for Sclk and Mosi, and to 1 for Cs_n.
  - Shifters and bit counter cleared.
- Synchronisation:
  - 2-flop synchroniser on each of Sclk, Cs_n, Mosi.
  - Third register on synced Sclk and Cs_n for edge detection.
  - Rise = s & ~s_d; fall = ~s & s_d.
  - Pin-to-detect latency is fixed at 3 Clk edges.
- Timing requirement: Sclk high and low phases each ≥4 Clk periods. Slower Clk is out of spec.
- Frame start (synced Cs_n fall):
  - Bit counter cleared to 0.
  - Tx shifter loaded from holding register, which clears TxFull.
  - If holding register empty: load all zeros and pulse TxUnderrun.
  - Miso driven with shifter MSB on the following cycle.
- Sclk rise, Cs_n low:
  - Shift synced Mosi into rx shifter LSB; counter +1.
  - When counter was SIZE-1: RxData <= {rx_shift[SIZE-2:0], Mosi}, RxValid=1 for one cycle, counter wraps to 0.
- Sclk fall, Cs_n low:
  - Tx shifter shifts left by 1; Miso = new MSB.
  - Exception: if the preceding rise completed a word, reload the shifter from the holding register instead, with the same underrun rule.
  - Back-to-back words in one frame therefore need no Cs_n toggle.
- Cs_n high:
  - Sclk edges ignored; Miso=0 (no tri-state, external buffer gated by Cs_n).
  - Rx/tx shifter contents unchanged until next frame start.
- Synced Cs_n rise with counter ≠ 0:
  - Partial word discarded, no RxValid, FrameErr pulses one cycle, counter cleared.
  - With counter = 0: no pulse.
- Holding register:
  - TxWr with TxFull=0: capture TxData, TxFull=1 next cycle.
  - TxWr with TxFull=1: write dropped, contents unchanged.
  - TxWr in the same cycle as a shifter load: the load uses the pre-cycle holding state (old data, or zeros plus underrun if empty). The write then lands, leaving TxFull=1 with the new word.
- Simultaneous Cs_n fall and Sclk rise in one synced cycle: violates the mode-0 setup, so the frame start takes priority and the Sclk edge is ignored.
- Reset mid-frame: all state cleared immediately. The next frame needs a fresh synced Cs_n fall.

Test Plan (SIZE=8, Clk = 8× Sclk):
- TxWr 0xA5 → TxFull=1. Frame: Mosi 0x3C → Miso bits 1,0,1,0,0,1,0,1. RxData=0x3C, RxValid single pulse 3 Clk after 8th Sclk rise. TxFull=0 after Cs_n fall.
- Two-word frame, TxWr 0x11 before Cs_n fall and TxWr 0x22 during word 1: Mosi 0xF0,0x0F → RxValid twice (0xF0, then 0x0F). Miso carries 0x11 then 0x22, no TxUnderrun.
- Frame with no TxWr → Miso all 0, TxUnderrun one pulse at Cs_n fall. RxData still updated.
- Cs_n raised after 5 Sclk rises → FrameErr one pulse, no RxValid, RxData keeps previous value. Next full frame receives correctly.
- TxWr 0x55 then TxWr 0x77 with no frame between → holding keeps 0x55. The next frame transmits 0x55.
- Assert Rst_n=0 mid-word (after 3 bits) → all outputs 0 asynchronously. The post-reset frame with Mosi 0x81 yields RxData=0x81.
